// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU I/O port peripherals: transmit FSM
// states, status-byte bit positions and UART frame geometry.
package cpu_io_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  localparam int unsigned ST_FULL = 0;
  localparam int unsigned ST_BUSY = 1;
  localparam int unsigned ST_OVF  = 2;

  // start + 8 data + stop
  localparam int unsigned FRAME_BITS = 10;

  // Pack the status byte returned on the CPU input port.
  function automatic logic [7:0] make_status(input logic ovf, input logic busy,
                                             input logic full);
    logic [7:0] s;
    s = '0;
    s[ST_FULL] = full;
    s[ST_BUSY] = busy;
    s[ST_OVF]  = ovf;
    return s;
  endfunction

endpackage

// File: rtl/cpu_uart_tx_if.sv
// CPU output/input port bundle for the UART transmitter: write strobe and
// data from the CPU, status and occupancy back to it.
interface cpu_uart_tx_if #(
  parameter int unsigned FIFO_DEPTH = 4
) ();
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             wr_en;
  logic [7:0]       wr_data;
  logic             full;
  logic             busy;
  logic             overflow;
  logic [LVL_W-1:0] level;
  logic [7:0]       status;

  modport master (
    output wr_en, wr_data,
    input  full, busy, overflow, level, status
  );

  modport slave (
    input  wr_en, wr_data,
    output full, busy, overflow, level, status
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. dout always shows the head
// entry while empty is low; pointers wrap modulo DEPTH (power of two).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array; no reset needed, contents are qualified by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_uart_tx.sv
// UART 8N1 transmitter on the CPU output-port bus. Bytes written by the CPU
// queue in a small FIFO and are serialised LSB first on tx; a status byte
// (overflow, busy, full) is returned for polling.
module cpu_uart_tx
  import cpu_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  cpu_uart_tx_if.slave  bus,
  output logic          tx
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [7:0]       fifo_dout;
  logic [LVL_W-1:0] fifo_level;
  logic             busy_w;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.wr_en),
    .pop   (fifo_pop),
    .din   (bus.wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // State, baud counter, shift register and registered serial output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Sticky overflow flag: a write arrived while the FIFO was full.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (bus.wr_en && fifo_full) begin
      ovf_q <= 1'b1;
    end
  end

  // Next-state logic; tx is derived from the next state so it is registered
  // and changes in the same edge the FSM moves.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q - CNT_W'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    tx_d     = 1'b1;

    case (state_q)
      TX_IDLE: begin
        cnt_d = cnt_q;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = BIT_LAST;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (cnt_q == '0) begin
          cnt_d   = BIT_LAST;
          idx_d   = '0;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = BIT_LAST;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            cnt_d    = BIT_LAST;
            state_d  = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase

    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign busy_w       = (state_q != TX_IDLE) || !fifo_empty;
  assign tx           = tx_q;
  assign bus.full     = fifo_full;
  assign bus.busy     = busy_w;
  assign bus.overflow = ovf_q;
  assign bus.level    = fifo_level;
  assign bus.status   = make_status(ovf_q, busy_w, fifo_full);

endmodule

// File: tb/tb_cpu_uart_tx.sv
// Bench for cpu_uart_tx: directed writes push expected bytes into a
// scoreboard queue; an independent monitor decodes frames from tx and
// compares them against the queue.
module tb_cpu_uart_tx;
  import cpu_io_pkg::*;

  localparam int CPB = 4;
  localparam int FRAME_CYC = CPB * FRAME_BITS;

  logic clk;
  logic reset;
  logic tx;

  cpu_uart_tx_if #(.FIFO_DEPTH(4)) bus ();

  cpu_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          errs = 0;
  int          frames = 0;
  logic [7:0]  exp_q[$];
  int          frame_starts[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decode 8N1 frames from tx on the falling edge.
  bit         in_frame = 0;
  int         pos = 0;
  logic [9:0] bits;
  bit         glitch;
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 0;
    end else begin
      if (!in_frame && tx === 1'b0) begin
        in_frame = 1;
        pos = 0;
        glitch = 0;
        bits = '0;
        frame_starts.push_back(cyc);
      end
      if (in_frame) begin
        if (pos % CPB == 0) bits[pos / CPB] = tx;
        else if (tx !== bits[pos / CPB]) glitch = 1;
        pos++;
        if (pos == FRAME_CYC) begin
          in_frame = 0;
          frames++;
          chk("frame_shape", {glitch, bits[0], bits[9]}, 3'b001);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
          end else begin
            chk("frame_data", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] b, input bit accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (accept) exp_q.push_back(b);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < max_cyc) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, n >= max_cyc}, 32'd0);
  endtask

  int e0;
  int f0;
  int s0;
  logic [7:0] wrap_vals [9];

  initial begin
    wrap_vals = '{8'h3C, 8'hFF, 8'h00, 8'h81, 8'h5A, 8'hC3, 8'h7E, 8'h12, 8'hED};
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    reset       = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    // Reset values
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("rst_level", {29'd0, bus.level}, 32'd0);
    chk("rst_status", {24'd0, bus.status}, 32'h00);

    // Single byte A5
    f0 = frames;
    write(8'hA5, 1);
    e0 = cyc;
    chk("single_level_after_E", {29'd0, bus.level}, 32'd1);
    chk("single_tx_after_E", {31'd0, tx}, 32'd1);
    tick();
    chk("single_tx_low_E1", {31'd0, tx}, 32'd0);
    chk("single_level_E1", {29'd0, bus.level}, 32'd0);
    chk("single_status_busy", {24'd0, bus.status}, 32'h02);
    while (cyc < e0 + 40) tick();
    chk("single_busy_in_stop", {31'd0, bus.busy}, 32'd1);
    chk("single_tx_stop", {31'd0, tx}, 32'd1);
    tick();
    chk("single_busy_drop", {31'd0, bus.busy}, 32'd0);
    chk("single_frames", frames - f0, 32'd1);

    // Back-to-back 01, 80
    f0 = frames;
    s0 = frame_starts.size();
    write(8'h01, 1);
    write(8'h80, 1);
    wait_idle(200);
    chk("b2b_frames", frames - f0, 32'd2);
    if (frame_starts.size() >= s0 + 2)
      chk("b2b_gap", frame_starts[s0+1] - frame_starts[s0], FRAME_CYC);
    else
      chk("b2b_starts", frame_starts.size() - s0, 32'd2);

    // Fill / overflow: 10..14 accepted, 15 dropped
    f0 = frames;
    write(8'h10, 1);
    write(8'h11, 1);
    write(8'h12, 1);
    write(8'h13, 1);
    write(8'h14, 1);
    write(8'h15, 0);
    chk("fill_ovf", {31'd0, bus.overflow}, 32'd1);
    chk("fill_status", {24'd0, bus.status}, 32'h07);
    chk("fill_level", {29'd0, bus.level}, 32'd4);
    wait_idle(400);
    chk("fill_frames", frames - f0, 32'd5);
    chk("fill_ovf_sticky", {31'd0, bus.overflow}, 32'd1);

    // Write on pop cycle while full
    do_reset();
    chk("popw_ovf_cleared", {31'd0, bus.overflow}, 32'd0);
    f0 = frames;
    write(8'h20, 1);
    e0 = cyc;
    write(8'h21, 1);
    write(8'h22, 1);
    write(8'h23, 1);
    write(8'h24, 1);
    chk("popw_level_full", {29'd0, bus.level}, 32'd4);
    chk("popw_ovf_before", {31'd0, bus.overflow}, 32'd0);
    while (cyc < e0 + 40) tick();
    chk("popw_full_before", {31'd0, bus.full}, 32'd1);
    write(8'h25, 0);
    chk("popw_level_after", {29'd0, bus.level}, 32'd3);
    chk("popw_ovf_after", {31'd0, bus.overflow}, 32'd1);
    chk("popw_full_after", {31'd0, bus.full}, 32'd0);
    wait_idle(400);
    chk("popw_frames", frames - f0, 32'd5);

    // Reset mid-frame, during data bit 3
    do_reset();
    write(8'h30, 1);
    e0 = cyc;
    write(8'h31, 1);
    write(8'h32, 1);
    while (cyc < e0 + 18) tick();
    chk("midrst_level_before", {29'd0, bus.level}, 32'd2);
    f0 = frames;
    do_reset();
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_level", {29'd0, bus.level}, 32'd0);
    chk("midrst_status", {24'd0, bus.status}, 32'h00);
    repeat (100) tick();
    chk("midrst_no_frames", frames - f0, 32'd0);
    chk("midrst_tx_idle", {31'd0, tx}, 32'd1);

    // Pointer wrap: 9 writes a frame apart
    f0 = frames;
    for (int i = 0; i < 9; i++) begin
      write(wrap_vals[i], 1);
      repeat (44) tick();
    end
    wait_idle(200);
    chk("wrap_frames", frames - f0, 32'd9);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_uart_tx.md
# cpu_uart_tx

Serial transmit port hanging directly off the monocycle CPU's 8-bit output-port bus. A byte written by the CPU to its output port is queued in a small FIFO and shifted out as a standard 8N1 UART frame on `tx`. A status byte is returned for the CPU to read on one of its 8-bit input ports, so software can poll for `full`/`busy` before writing.

## Interface
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; legal range ≥ 2.
- `FIFO_DEPTH`, 4: number of queued bytes; must be a power of two, ≥ 2.
- `clk`  in  1  system clock; everything samples on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  one-cycle write strobe from the CPU output-port decode.
- `wr_data`  in  8  byte to transmit; sampled with `wr_en`.
- `tx`  out  1  serial line; idles high.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `busy`  out  1  frame in progress, or FIFO not empty.
- `overflow`  out  1  sticky: a write was dropped because the FIFO was full.
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `status`  out  8  `{5'b0, overflow, busy, full}`; wired to a CPU input port.

## Operation
- Reset values: `tx`=1, `full`=0, `busy`=0, `overflow`=0, `level`=0, `status`=8'h00, FSM in IDLE, FIFO pointers at 0.
- Write: when `wr_en && !full`, push `wr_data` and increment `level`. When `wr_en && full`, drop the byte and set `overflow`. `full` is evaluated on the registered level, so a write is rejected when full even if a pop happens in the same cycle.
- `overflow` is cleared only by `reset`.
- FSM states:
  - IDLE (`tx`=1): if `level`≠0, pop the head byte into the shift register, load the baud counter, and go to START.
  - START (`tx`=0): one bit time, then go to DATA with bit index 0.
  - DATA (`tx`=shift[0]): bits are sent LSB first. At the end of each bit time, shift right. After bit 7, go to STOP.
  - STOP (`tx`=1): one bit time. At the end, if `level`≠0, pop and go directly to START, so back-to-back frames have no idle gap. Otherwise go to IDLE.
- Baud counter: loaded with `CLKS_PER_BIT-1` and decremented each cycle. The bit ends in the cycle the counter reads 0.
- Simultaneous push and pop: `level` is unchanged and the data are both valid.
- Pointers wrap modulo `FIFO_DEPTH`.
- `busy` = (state≠IDLE) || (`level`≠0).

## Timing
- `tx` is registered, with no combinational path from inputs to `tx`.
- Write accepted at edge E while IDLE with an empty FIFO:
  - `level` becomes 1 after E.
  - Pop happens at E+1.
  - `tx` goes low after E+1.
- A frame lasts exactly 10·`CLKS_PER_BIT` cycles: start, 8 data bits, stop.
- `full`, `level`, `busy` and `status` update in the cycle following the push or pop edge.
- Reset asserted mid-frame: at the next edge `tx`=1, the FIFO is emptied, and `overflow` is cleared. No partial frame resumes.

## Structure
- Shared package `cpu_io_pkg` holds:
  - the FSM state enum (`TX_IDLE`, `TX_START`, `TX_DATA`, `TX_STOP`);
  - the status bit positions (`ST_FULL`=0, `ST_BUSY`=1, `ST_OVF`=2);
  - the UART frame length constant (10).
- Sub-module `sync_fifo` (parameterised width/depth):
  - ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `level`;
  - first-word-fall-through, so `dout` is valid whenever `empty`=0.
- The top level holds the FSM, baud counter, shift register and status logic.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Single byte: write 8'hA5 after reset.
  - `tx` low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4.
  - `busy` drops right after the stop bit.
- Back-to-back: write 8'h01, 8'h80 on consecutive cycles.
  - Two frames totalling 80 cycles, with the stop of frame 1 followed immediately by the start of frame 2.
- Fill/overflow: 6 consecutive writes 8'h10..8'h15 while the first frame starts.
  - The first byte pops at the second edge, so 5 bytes are accepted (8'h10–8'h14).
  - 8'h15 is dropped; `overflow`=1 and `status`=8'h07.
  - Exactly 5 frames are transmitted.
- Write on the pop cycle with FIFO full:
  - The write is rejected and `overflow` is set.
  - `level` goes from 4 to 3.
- Reset mid-frame: assert `reset` during DATA bit 3 with 2 bytes queued.
  - Next cycle: `tx`=1, `level`=0, `status`=8'h00.
  - No further frames appear.
- Pointer wrap: 9 writes spaced one frame apart.
  - All 9 bytes are serialised correctly in order.
